// File: rtl/fsqrt_issue.sv
// Issue/retire front end for the pipelined fsqrt unit with a register busy map.
// Define FSQRT_TAG_CHECK_EN to add the shadow tag pipeline and the sticky tag_err.
module fsqrt_issue #(
    parameter int LATENCY = 2,
    parameter int NREG    = 32,
    parameter int AW      = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_x,
    input  logic [AW-1:0]                  req_src,
    input  logic [AW-1:0]                  req_dst,
    output logic [31:0]                    fs_x,
    output logic                           fs_flag,
    output logic [AW-1:0]                  fs_add,
    input  logic [31:0]                    fs_y,
    input  logic                           fs_flagout,
    input  logic [AW-1:0]                  fs_addout,
    output logic                           wb_en,
    output logic [AW-1:0]                  wb_addr,
    output logic [31:0]                    wb_data,
    output logic [NREG-1:0]                busy_map,
    output logic [$clog2(LATENCY+3)-1:0]   inflight,
    output logic                           idle,
    output logic                           tag_err
);

    localparam int IW  = $clog2(LATENCY + 3);
    localparam int ICW = $clog2(LATENCY + 1);
    localparam logic [IW-1:0]  IMAX = IW'(LATENCY + 1);
    localparam logic [ICW-1:0] IGN0 = ICW'(LATENCY);

    logic            accept;
    logic            ret_ok;
    logic [AW-1:0]   ret_addr;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [ICW-1:0]  ign_cnt;

    assign req_ready = !rst && !busy_map[req_src] && !busy_map[req_dst];
    assign accept    = req_valid && req_ready;
    assign idle      = (inflight == '0);

    // Returns launched before a reset still drain out of fsqrt; drop them.
    assign ret_ok = fs_flagout && (ign_cnt == '0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (accept)
            set_mask[req_dst] = 1'b1;
        if (ret_ok)
            clr_mask[ret_addr] = 1'b1;
    end

`ifdef FSQRT_TAG_CHECK_EN
    typedef struct packed {
        logic          v;
        logic [AW-1:0] dst;
    } tag_t;

    tag_t sh [LATENCY+1];
    logic tag_bad;

    assign ret_addr = sh[LATENCY].dst;
    assign tag_bad  = (fs_flagout != sh[LATENCY].v) ||
                      (fs_flagout && sh[LATENCY].v &&
                       (fs_addout != sh[LATENCY].dst));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++)
                sh[i] <= '0;
            tag_err <= 1'b0;
        end else begin
            sh[0].v   <= accept;
            sh[0].dst <= accept ? req_dst : '0;
            for (int i = 1; i <= LATENCY; i++)
                sh[i] <= sh[i-1];
            if (ign_cnt == '0 && tag_bad)
                tag_err <= 1'b1;
        end
    end
`else
    assign ret_addr = fs_addout;
    assign tag_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_x     <= '0;
            fs_flag  <= 1'b0;
            fs_add   <= '0;
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            busy_map <= '0;
            inflight <= '0;
            ign_cnt  <= IGN0;
        end else begin
            fs_flag <= accept;
            fs_add  <= accept ? req_dst : '0;
            fs_x    <= accept ? req_x : '0;
            wb_en   <= ret_ok;
            wb_addr <= ret_ok ? ret_addr : '0;
            wb_data <= ret_ok ? fs_y : '0;
            // A fresh set wins over a stray clear of the same register.
            busy_map <= (busy_map & ~clr_mask) | set_mask;
            if (accept && !ret_ok && inflight != IMAX)
                inflight <= inflight + 1'b1;
            else if (!accept && ret_ok && inflight != '0)
                inflight <= inflight - 1'b1;
            if (ign_cnt != '0)
                ign_cnt <= ign_cnt - 1'b1;
        end
    end

endmodule
